// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional build macro DIV_EARLY_OUT_EN: finish in one cycle when |rs1| < |rs2|.
module riscv_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            stall_req,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_dvd;
  logic [XLEN-1:0]   r_dvs;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic              r_want_rem;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  // Operand decode, valid only while the request is sitting in IDLE.
  logic              w_signed;
  logic              w_s1;
  logic              w_s2;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic              w_accept;
  logic              w_dvz;
  logic              w_ovf;
  logic              w_early;
  logic [XLEN-1:0]   w_min;
  logic [XLEN-1:0]   w_special_res;

  assign w_min    = {1'b1, {(XLEN-1){1'b0}}};
  assign w_signed = ~funct3[0];
  assign w_s1     = w_signed & rs1_value[XLEN-1];
  assign w_s2     = w_signed & rs2_value[XLEN-1];
  assign w_abs1   = w_s1 ? (~rs1_value + 1'b1) : rs1_value;
  assign w_abs2   = w_s2 ? (~rs2_value + 1'b1) : rs2_value;
  assign w_accept = (r_state == S_IDLE) & start & funct3[2] & ~flush;
  assign w_dvz    = (rs2_value == '0);
  assign w_ovf    = w_signed & (rs1_value == w_min) & (rs2_value == '1);

`ifdef DIV_EARLY_OUT_EN
  assign w_early  = ~w_dvz & (w_abs1 < w_abs2);
`else
  assign w_early  = 1'b0;
`endif

  // Early-out shares the divide-by-zero remainder rule: quotient 0, remainder rs1.
  always_comb begin
    w_special_res = '0;
    if (w_dvz)
      w_special_res = funct3[1] ? rs1_value : '1;
    else if (w_ovf)
      w_special_res = funct3[1] ? '0 : w_min;
    else
      w_special_res = funct3[1] ? rs1_value : '0;
  end

  // One restoring step. The shifted remainder needs XLEN+1 bits for the compare;
  // after a successful subtract the difference is below the divisor, so XLEN bits hold it.
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quo_nx;
  logic [XLEN-1:0]   w_fin;

  assign w_rem_sh = {r_rem, r_dvd[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_sub    = w_rem_sh[XLEN-1:0] - r_dvs;
  assign w_rem_nx = w_ge ? w_sub : w_rem_sh[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

  always_comb begin
    w_fin = '0;
    if (r_want_rem)
      w_fin = r_r_neg ? (~w_rem_nx + 1'b1) : w_rem_nx;
    else
      w_fin = r_q_neg ? (~w_quo_nx + 1'b1) : w_quo_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_want_rem <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_want_rem <= funct3[1];
            r_q_neg    <= w_s1 ^ w_s2;
            r_r_neg    <= w_s1;
            r_dvd      <= w_abs1;
            r_dvs      <= w_abs2;
            r_rem      <= '0;
            r_quo      <= '0;
            if (w_dvz | w_ovf | w_early) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt    <= CNT_W'(XLEN - 1);
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_result <= w_fin;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // stall_req drops in DONE so the instruction leaves EX together with its result.
  assign stall_req = w_accept | (r_state == S_CALC);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule
